arc4_smem_arbiter: RTL

Arbiter that shares the single-port 256x8 S-array RAM between the three ARC4 engines: init (requester 0), KSA (requester 1) and PRGA (requester 2). Each engine requests ownership, holds the RAM for a burst of reads and writes, then releases it. The arbiter steers address, write data and write enable to the RAM and routes read data back to the owner with a one-cycle tagged valid. It sits between the engines and the S memory instance, under the top-level controller.

---
 rtl/arc4_smem_arbiter_if.sv | 36 +++
 rtl/arc4_smem_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/arc4_smem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : arc4_smem_arbiter_if
// Description : Engine-side bus and RAM-side port bundle of the S-array arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface arc4_smem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [2:0]          req;
    logic [2:0]          gnt;
    logic [2:0]          acc_en;
    logic [2:0]          wr;
    logic [3*ADDR_W-1:0] addr;
    logic [3*DATA_W-1:0] wrdata;
    logic [DATA_W-1:0]   rddata;
    logic [2:0]          rdvalid;
    logic                err;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wrdata;
    logic                mem_wren;
    logic [DATA_W-1:0]   mem_q;

    // master = engines plus RAM instance; slave = the arbiter
    modport master (
        output req, acc_en, wr, addr, wrdata, mem_q,
        input  gnt, rddata, rdvalid, err, mem_addr, mem_wrdata, mem_wren
    );

    modport slave (
        input  req, acc_en, wr, addr, wrdata, mem_q,
        output gnt, rddata, rdvalid, err, mem_addr, mem_wrdata, mem_wren
    );
endinterface
`default_nettype wire

// File: rtl/arc4_smem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : arc4_smem_arbiter
// Description : Shares the 256x8 S-array RAM between init, KSA and PRGA engines.
//               Define ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module arc4_smem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    arc4_smem_arbiter_if.slave bus
);
    localparam int N_REQ = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  rd_pend_q, rd_pend_d;
    logic              err_q, err_d;

    logic [N_REQ-1:0]  w_cand;
    logic [N_REQ-1:0]  w_win;
    logic [N_REQ-1:0]  w_legal;
    logic              w_release;
    logic              w_arb;
    logic [1:0]        w_own_idx;
    logic [ADDR_W-1:0] w_addr  [N_REQ];
    logic [DATA_W-1:0] w_wdata [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_addr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata[gi] = bus.wrdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // A releasing owner is excluded so the handoff can skip straight to a peer
    assign w_cand    = bus.req & ~gnt_q;
    assign w_release = |(gnt_q & ~bus.req);
    assign w_arb     = (state_q == ST_IDLE) || w_release;
    assign w_legal   = bus.acc_en & gnt_q;
    assign w_own_idx = gnt_q[2] ? 2'd2 : (gnt_q[1] ? 2'd1 : 2'd0);

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] last_q, last_d;
    logic [1:0] w_start;
    logic [2:0] w_idx;
    logic       w_found;

    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        w_start = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, w_start} + 3'(k);
            if (w_idx >= 3'd3) begin
                w_idx = w_idx - 3'd3;
            end
            if (!w_found && w_cand[w_idx[1:0]]) begin
                w_win[w_idx[1:0]] = 1'b1;
                w_found           = 1'b1;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt_d[0]) begin
            last_d = 2'd0;
        end else if (gnt_d[1]) begin
            last_d = 2'd1;
        end else if (gnt_d[2]) begin
            last_d = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 2'd2;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Lowest set bit wins: 0 > 1 > 2
    assign w_win = w_cand & (~w_cand + 3'd1);
`endif

    always_comb begin
        gnt_d     = gnt_q;
        if (w_arb) begin
            gnt_d = w_win;
        end
        state_d   = (gnt_d != '0) ? ST_OWNED : ST_IDLE;
        rd_pend_d = w_legal & ~bus.wr;
        err_d     = err_q | (|(bus.acc_en & ~gnt_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            rd_pend_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rd_pend_q <= rd_pend_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        bus.mem_addr   = '0;
        bus.mem_wrdata = '0;
        bus.mem_wren   = 1'b0;
        if (gnt_q != '0) begin
            bus.mem_addr   = w_addr[w_own_idx];
            bus.mem_wrdata = w_wdata[w_own_idx];
            bus.mem_wren   = |(w_legal & bus.wr);
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.rdvalid = rd_pend_q;
    assign bus.err     = err_q;
    assign bus.rddata  = bus.mem_q;

endmodule
`default_nettype wire
